// File: rtl/vga_pkg.sv
// Shared constants for the 640x480@60 scan-out path: raster timing,
// framebuffer geometry, colour field layout and VRAM block organisation.
package vga_pkg;

  // Raster timing (pixel clocks / lines)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Framebuffer: each stored pixel covers a 4x4 block of the screen
  localparam int VGA_FB_WIDTH = VGA_H_ACTIVE / 4;

  // Counter and address widths
  localparam int CNT_W  = 10;
  localparam int ADDR_W = 15;

  // VRAM: 5 blocks of 4K bits, addr[14:12] selects the block
  localparam int VRAM_BLOCKS     = 5;
  localparam int VRAM_BLOCK_BITS = 4096;
  localparam int VRAM_OFFSET_W   = 12;

  // Colour fields, packed {red, green, blue}
  localparam int RED_W   = 2;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 3;
  localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

  typedef struct packed {
    logic [RED_W-1:0]   red;
    logic [GREEN_W-1:0] green;
    logic [BLUE_W-1:0]  blue;
  } rgb_t;

  localparam logic [RGB_W-1:0] VGA_FG_COLOR = 8'hFF;
  localparam logic [RGB_W-1:0] VGA_BG_COLOR = 8'h00;

endpackage

// File: rtl/vga_timing.sv
// Raster counters and region decode. Besides the current-state flags it
// exposes the next horizontal count and next-cycle visibility, so the
// address register can be loaded in step with the counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] v_cnt,
  output logic [CNT_W-1:0] h_nxt,
  output logic             visible,
  output logic             visible_nxt,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             line_end,
  output logic             frame_wrap,
  output logic             first_pix
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  // Next state of the horizontal and vertical counters
  always_comb begin
    line_end   = (h_cnt_q == H_LAST);
    frame_wrap = line_end && (v_cnt_q == V_LAST);
    h_cnt_d    = line_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d    = v_cnt_q;
    if (frame_wrap) begin
      v_cnt_d = '0;
    end else if (line_end) begin
      v_cnt_d = v_cnt_q + 1'b1;
    end
  end

  // Region decode for the current and the next counter state
  always_comb begin
    visible     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    visible_nxt = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    hsync_raw   = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
    vsync_raw   = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
    first_pix   = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  assign v_cnt = v_cnt_q;
  assign h_nxt = h_cnt_d;

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/vga_scan.sv
// Display-side VRAM consumer: raster timing, multiplier-free pixel address
// generation and a two-stage pipeline turning the 1-bit pixel into RGB+sync.
// Output at any clk reflects the counter state two clks earlier.
module vga_scan
  import vga_pkg::*;
#(
  parameter int               H_ACTIVE = VGA_H_ACTIVE,
  parameter int               H_FP     = VGA_H_FP,
  parameter int               H_SYNC   = VGA_H_SYNC,
  parameter int               H_BP     = VGA_H_BP,
  parameter int               V_ACTIVE = VGA_V_ACTIVE,
  parameter int               V_FP     = VGA_V_FP,
  parameter int               V_SYNC   = VGA_V_SYNC,
  parameter int               V_BP     = VGA_V_BP,
  parameter int               FB_WIDTH = H_ACTIVE / 4,
  parameter logic [RGB_W-1:0] FG_COLOR = VGA_FG_COLOR,
  parameter logic [RGB_W-1:0] BG_COLOR = VGA_BG_COLOR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vram_data,
  output logic [ADDR_W-1:0]  vga_address,
  output logic [RED_W-1:0]   red,
  output logic [GREEN_W-1:0] green,
  output logic [BLUE_W-1:0]  blue,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               frame_start
);

  localparam logic [ADDR_W-1:0] FB_STEP = ADDR_W'(FB_WIDTH);
  localparam logic [CNT_W-1:0]  V_ACT   = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic             visible, visible_nxt;
  logic             hsync_raw, vsync_raw;
  logic             line_end, frame_wrap, first_pix;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .v_cnt       (v_cnt),
    .h_nxt       (h_nxt),
    .visible     (visible),
    .visible_nxt (visible_nxt),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .line_end    (line_end),
    .frame_wrap  (frame_wrap),
    .first_pix   (first_pix)
  );

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] vga_address_q, vga_address_d;
  logic              vis_p1_q, vis_p1_d;
  logic              hs_p1_q, hs_p1_d;
  logic              vs_p1_q, vs_p1_d;
  logic              fs_p1_q, fs_p1_d;
  rgb_t              rgb_p2_q, rgb_p2_d;
  logic              hsync_p2_q, hsync_p2_d;
  logic              vsync_p2_q, vsync_p2_d;
  logic              blank_p2_q, blank_p2_d;
  logic              fs_p2_q, fs_p2_d;

  // Stage 0: row base steps one framebuffer row every 4 visible lines;
  // the address is built from next-state values so it tracks the counters.
  always_comb begin
    row_base_d = row_base_q;
    if (frame_wrap) begin
      row_base_d = '0;
    end else if (line_end && (v_cnt[1:0] == 2'd3) && (v_cnt < V_ACT)) begin
      row_base_d = row_base_q + FB_STEP;
    end
    vga_address_d = visible_nxt ? row_base_d + ADDR_W'(h_nxt[CNT_W-1:2]) : '0;
  end

  // Stage 1: hold control flags for the one-clk VRAM read
  always_comb begin
    vis_p1_d = visible;
    hs_p1_d  = hsync_raw;
    vs_p1_d  = vsync_raw;
    fs_p1_d  = first_pix;
  end

  // Stage 2: colour lookup with blanking, sync/blank aligned to rgb
  always_comb begin
    rgb_p2_d   = '0;
    if (vis_p1_q) begin
      rgb_p2_d = vram_data ? rgb_t'(FG_COLOR) : rgb_t'(BG_COLOR);
    end
    hsync_p2_d = hs_p1_q;
    vsync_p2_d = vs_p1_q;
    blank_p2_d = !vis_p1_q;
    fs_p2_d    = fs_p1_q;
  end

  // Pipeline registers; reset returns outputs to idle immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_base_q    <= '0;
      vga_address_q <= '0;
      vis_p1_q      <= 1'b0;
      hs_p1_q       <= 1'b1;
      vs_p1_q       <= 1'b1;
      fs_p1_q       <= 1'b0;
      rgb_p2_q      <= '0;
      hsync_p2_q    <= 1'b1;
      vsync_p2_q    <= 1'b1;
      blank_p2_q    <= 1'b1;
      fs_p2_q       <= 1'b0;
    end else begin
      row_base_q    <= row_base_d;
      vga_address_q <= vga_address_d;
      vis_p1_q      <= vis_p1_d;
      hs_p1_q       <= hs_p1_d;
      vs_p1_q       <= vs_p1_d;
      fs_p1_q       <= fs_p1_d;
      rgb_p2_q      <= rgb_p2_d;
      hsync_p2_q    <= hsync_p2_d;
      vsync_p2_q    <= vsync_p2_d;
      blank_p2_q    <= blank_p2_d;
      fs_p2_q       <= fs_p2_d;
    end
  end

  assign vga_address = vga_address_q;
  assign red         = rgb_p2_q.red;
  assign green       = rgb_p2_q.green;
  assign blue        = rgb_p2_q.blue;
  assign hsync       = hsync_p2_q;
  assign vsync       = vsync_p2_q;
  assign blank       = blank_p2_q;
  assign frame_start = fs_p2_q;

endmodule
